cp0_exc_ctrl: RTL and testbench

Sequential exception/interrupt controller that owns the coprocessor-0 state (Count, Compare, Status, Cause, EPC). It arbitrates between commit-stage synchronous exceptions, pending hardware and timer interrupts, `eret`, and `mtc0` writes. For each accepted event it runs a two-cycle flush-then-redirect sequence toward the fetch stage. It sits beside the commit stage and replaces purely combinational CP0 handling with a clocked, prioritised sequencer.

---
 rtl/cp0_exc_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: Count/Compare/Status/Cause/EPC state
// plus a prioritised IDLE -> FLUSH -> REDIR redirect sequencer.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_3000,
    parameter logic [31:0] STATUS_RST = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  irq,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] int_pc,
    input  logic        eret,
    input  logic        cp0_wr,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    localparam logic [4:0] R_COUNT   = 5'd9;
    localparam logic [4:0] R_COMPARE = 5'd11;
    localparam logic [4:0] R_STATUS  = 5'd12;
    localparam logic [4:0] R_CAUSE   = 5'd13;
    localparam logic [4:0] R_EPC     = 5'd14;

    // Implemented Status bits: IM[15:8], EXL[1], IE[0]
    localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;

    logic [1:0]  state;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] epc;
    logic [31:0] target;
    logic        cause_bd;
    logic [1:0]  cause_sw;
    logic [4:0]  cause_code;
    logic        timer_pend;

    logic [7:0]  ip;
    logic [31:0] cause;
    logic        idle;
    logic        exl;
    logic        int_pend;
    logic        take_exc;
    logic        take_int;
    logic        take_eret;
    logic        take_wr;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic [31:0] count_nxt;

    // Pending bits: timer shares IP[15] with irq[5], software bits at IP[9:8]
    assign ip    = {irq[5] | timer_pend, irq[4:0], cause_sw};
    assign cause = {cause_bd, 15'b0, ip, 1'b0, cause_code, 2'b00};

    assign idle     = (state == S_IDLE);
    assign exl      = status[1];
    assign int_pend = (|(ip & status[15:8])) & status[0] & ~exl;

    // Fixed priority: exception > interrupt > eret > mtc0
    assign take_exc  = idle & exc_valid;
    assign take_int  = idle & ~exc_valid & int_pend;
    assign take_eret = idle & ~exc_valid & ~int_pend & eret;
    assign take_wr   = idle & ~exc_valid & ~int_pend & ~eret & cp0_wr;

    assign wr_count   = take_wr & (cp0_addr == R_COUNT);
    assign wr_compare = take_wr & (cp0_addr == R_COMPARE);
    assign wr_status  = take_wr & (cp0_addr == R_STATUS);
    assign wr_cause   = take_wr & (cp0_addr == R_CAUSE);
    assign wr_epc     = take_wr & (cp0_addr == R_EPC);

    assign count_nxt = wr_count ? cp0_wdata : count + 32'd1;

    // Free-running Count and the sticky Compare-match flag
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 32'd0;
            compare    <= 32'd0;
            timer_pend <= 1'b0;
        end else begin
            count <= count_nxt;
            if (wr_compare) begin
                compare    <= cp0_wdata;
                timer_pend <= 1'b0;
            end else if (count_nxt == compare) begin
                timer_pend <= 1'b1;
            end
        end
    end

    // Status: EXL set on entry, cleared on eret, full write via mtc0
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= STATUS_RST & STATUS_MASK;
        end else if (take_exc || take_int) begin
            status[1] <= 1'b1;
        end else if (take_eret) begin
            status[1] <= 1'b0;
        end else if (wr_status) begin
            status <= cp0_wdata & STATUS_MASK;
        end
    end

    // Cause: code/BD captured on entry, only software IP bits writable
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_bd   <= 1'b0;
            cause_sw   <= 2'b00;
            cause_code <= 5'd0;
        end else if (take_exc) begin
            cause_code <= exc_code;
            if (!exl) begin
                cause_bd <= exc_bd;
            end
        end else if (take_int) begin
            cause_code <= 5'd0;
            cause_bd   <= 1'b0;
        end else if (wr_cause) begin
            cause_sw <= cp0_wdata[9:8];
        end
    end

    // EPC: nested exceptions (EXL already set) keep the original return PC
    always_ff @(posedge clk) begin
        if (rst) begin
            epc <= 32'd0;
        end else if (take_exc) begin
            if (!exl) begin
                epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
            end
        end else if (take_int) begin
            epc <= int_pc;
        end else if (wr_epc) begin
            epc <= cp0_wdata;
        end
    end

    // Sequencer: accept in IDLE, then one flush cycle and one redirect cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            target <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take_exc || take_int) begin
                        state  <= S_FLUSH;
                        target <= EXC_VECTOR;
                    end else if (take_eret) begin
                        state  <= S_FLUSH;
                        target <= epc;
                    end
                end
                S_FLUSH: state <= S_REDIR;
                S_REDIR: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stall       = ~idle;
    assign flush       = (state == S_FLUSH);
    assign redirect    = (state == S_REDIR);
    assign redirect_pc = redirect ? target : 32'd0;

    // Register read port, unmapped numbers read as zero
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            R_COUNT:   cp0_rdata = count;
            R_COMPARE: cp0_rdata = compare;
            R_STATUS:  cp0_rdata = status;
            R_CAUSE:   cp0_rdata = cause;
            R_EPC:     cp0_rdata = epc;
            default:   cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: vector table plus hand-written
// timer, masking and reset-mid-sequence scenarios.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  irq;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] int_pc;
    logic        eret;
    logic        cp0_wr;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;

    int tests = 0;
    int fails = 0;

    cp0_exc_ctrl dut (
        .clk(clk), .rst(rst), .irq(irq),
        .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_bd(exc_bd), .int_pc(int_pc),
        .eret(eret), .cp0_wr(cp0_wr), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic        er;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [2:0]  sfr;
        logic [31:0] rpc;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ev, logic [4:0] code, logic [31:0] pc,
                                logic bd, logic er, logic wr,
                                logic [4:0] addr, logic [31:0] wd,
                                logic [2:0] sfr, logic [31:0] rpc,
                                logic [31:0] rd);
        vec_t v;
        v.ev = ev; v.code = code; v.pc = pc; v.bd = bd;
        v.er = er; v.wr = wr; v.addr = addr; v.wd = wd;
        v.sfr = sfr; v.rpc = rpc; v.rd = rd;
        return v;
    endfunction

    function automatic vec_t idl(logic [4:0] a, logic [2:0] s,
                                 logic [31:0] p, logic [31:0] r);
        return mk(0, 0, 0, 0, 0, 0, a, 0, s, p, r);
    endfunction

    function automatic vec_t exc(logic [4:0] c, logic [31:0] pc, logic bd,
                                 logic [4:0] a, logic [31:0] r);
        return mk(1, c, pc, bd, 0, 0, a, 0, 3'b110, 0, r);
    endfunction

    function automatic vec_t ert(logic [4:0] a, logic [31:0] r);
        return mk(0, 0, 0, 0, 1, 0, a, 0, 3'b110, 0, r);
    endfunction

    function automatic vec_t wrv(logic [4:0] a, logic [31:0] d,
                                 logic [31:0] r);
        return mk(0, 0, 0, 0, 0, 1, a, d, 3'b000, 0, r);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0;
        eret = 0; cp0_wr = 0; cp0_wdata = 0;
    endtask

    task automatic out_chk(string name, logic [2:0] s, logic [31:0] p);
        chk({name, "_ctl"}, {29'd0, stall, flush, redirect}, {29'd0, s});
        chk({name, "_rpc"}, redirect_pc, p);
    endtask

    task automatic rd_chk(string name, logic [4:0] a, logic [31:0] e);
        cp0_addr = a;
        #1;
        chk(name, cp0_rdata, e);
    endtask

    task automatic do_wr(logic [4:0] a, logic [31:0] d);
        clr();
        cp0_wr = 1; cp0_addr = a; cp0_wdata = d;
        step();
        clr();
    endtask

    task automatic do_eret();
        clr();
        eret = 1;
        step();
        clr();
    endtask

    initial begin
        rst = 1; irq = 0; int_pc = 32'h300; cp0_addr = 0;
        clr();
        step();
        step();
        out_chk("rst", 3'b000, 0);
        rd_chk("rst_status", 12, 32'h1);
        rd_chk("rst_count", 9, 32'h0);
        rd_chk("rst_cause", 13, 32'h0);
        rd_chk("rst_epc", 14, 32'h0);
        rd_chk("rst_compare", 11, 32'h0);

        // syscall
        tbl.push_back(exc(8, 32'h40, 0, 14, 32'h40));
        tbl.push_back(idl(13, 3'b101, 32'h3000, 32'h20));
        tbl.push_back(idl(12, 3'b000, 0, 32'h3));
        tbl.push_back(ert(12, 32'h1));
        tbl.push_back(idl(14, 3'b101, 32'h40, 32'h40));
        tbl.push_back(idl(12, 3'b000, 0, 32'h1));
        // delay-slot wrap, then nested exception keeps EPC/BD
        tbl.push_back(exc(12, 0, 1, 14, 32'hFFFF_FFFC));
        tbl.push_back(idl(13, 3'b101, 32'h3000, 32'h8000_0030));
        tbl.push_back(idl(12, 3'b000, 0, 32'h3));
        tbl.push_back(exc(9, 32'h100, 0, 14, 32'hFFFF_FFFC));
        tbl.push_back(idl(13, 3'b101, 32'h3000, 32'h8000_0024));
        tbl.push_back(idl(12, 3'b000, 0, 32'h3));
        tbl.push_back(ert(12, 32'h1));
        tbl.push_back(idl(14, 3'b101, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        tbl.push_back(idl(13, 3'b000, 0, 32'h8000_0024));
        // software interrupt pending, then collision
        tbl.push_back(wrv(13, 32'h100, 32'h8000_0124));
        tbl.push_back(wrv(12, 32'h101, 32'h101));
        tbl.push_back(mk(1, 10, 32'h200, 0, 1, 1, 12, 0,
                         3'b110, 0, 32'h103));
        tbl.push_back(idl(14, 3'b101, 32'h3000, 32'h200));
        tbl.push_back(idl(13, 3'b000, 0, 32'h128));
        tbl.push_back(ert(12, 32'h101));
        tbl.push_back(idl(14, 3'b101, 32'h200, 32'h200));
        tbl.push_back(idl(12, 3'b000, 0, 32'h101));
        tbl.push_back(idl(14, 3'b110, 0, 32'h300));
        tbl.push_back(idl(13, 3'b101, 32'h3000, 32'h100));
        tbl.push_back(idl(12, 3'b000, 0, 32'h103));
        tbl.push_back(wrv(13, 0, 0));
        tbl.push_back(wrv(12, 32'h1, 32'h1));
        // Count wrap and write masks
        tbl.push_back(wrv(11, 32'h1000, 32'h1000));
        tbl.push_back(wrv(9, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        tbl.push_back(idl(9, 3'b000, 0, 32'h0));
        tbl.push_back(idl(9, 3'b000, 0, 32'h1));
        tbl.push_back(wrv(5, 32'h123, 0));
        tbl.push_back(wrv(12, 32'hFFFF_FFFF, 32'hFF03));
        tbl.push_back(wrv(12, 32'h1, 32'h1));

        rst = 0;
        foreach (tbl[i]) begin
            exc_valid = tbl[i].ev; exc_code = tbl[i].code;
            exc_pc = tbl[i].pc; exc_bd = tbl[i].bd;
            eret = tbl[i].er; cp0_wr = tbl[i].wr;
            cp0_addr = tbl[i].addr; cp0_wdata = tbl[i].wd;
            step();
            out_chk($sformatf("row%0d", i), tbl[i].sfr, tbl[i].rpc);
            chk($sformatf("row%0d_rd", i), cp0_rdata, tbl[i].rd);
        end
        clr();

        // timer interrupt
        int_pc = 32'h500;
        do_wr(12, 32'h8001);
        rd_chk("tmr_status", 12, 32'h8001);
        do_wr(9, 32'd100);
        do_wr(11, 32'd105);
        step();
        step();
        step();
        rd_chk("tmr_nopend", 13, 32'h0);
        out_chk("tmr_idle", 3'b000, 0);
        step();
        rd_chk("tmr_pend", 13, 32'h8000);
        out_chk("tmr_prepend", 3'b000, 0);
        step();
        out_chk("tmr_flush", 3'b110, 0);
        rd_chk("tmr_epc", 14, 32'h500);
        step();
        out_chk("tmr_redir", 3'b101, 32'h3000);
        rd_chk("tmr_cause", 13, 32'h8000);
        step();
        rd_chk("tmr_exl", 12, 32'h8003);
        do_wr(11, 32'h1000);
        rd_chk("tmr_clr", 13, 32'h0);
        do_eret();
        out_chk("tmr_eflush", 3'b110, 0);
        step();
        out_chk("tmr_eredir", 3'b101, 32'h500);
        rd_chk("tmr_estatus", 12, 32'h8001);
        step();
        out_chk("tmr_eidle", 3'b000, 0);

        // masking by EXL, taken right after eret completes
        do_wr(12, 32'h403);
        rd_chk("msk_status", 12, 32'h403);
        irq = 6'h01;
        for (int k = 0; k < 3; k++) begin
            step();
            out_chk($sformatf("msk_hold%0d", k), 3'b000, 0);
        end
        rd_chk("msk_cause", 13, 32'h400);
        do_eret();
        out_chk("msk_eflush", 3'b110, 0);
        int_pc = 32'h600;
        step();
        out_chk("msk_eredir", 3'b101, 32'h500);
        step();
        out_chk("msk_idle", 3'b000, 0);
        step();
        out_chk("msk_take", 3'b110, 0);
        rd_chk("msk_epc", 14, 32'h600);
        step();
        out_chk("msk_redir", 3'b101, 32'h3000);
        irq = 0;
        step();
        out_chk("msk_done", 3'b000, 0);
        rd_chk("msk_exl", 12, 32'h403);

        // reset during FLUSH
        exc_valid = 1; exc_code = 10; exc_pc = 32'h700;
        step();
        clr();
        out_chk("rmid_flush", 3'b110, 0);
        rst = 1;
        step();
        out_chk("rmid_rst", 3'b000, 0);
        rd_chk("rmid_status", 12, 32'h1);
        rd_chk("rmid_count", 9, 32'h0);
        rd_chk("rmid_epc", 14, 32'h0);
        rst = 0;
        step();
        out_chk("rmid_noredir", 3'b000, 0);
        step();
        out_chk("rmid_idle", 3'b000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
